// File: rtl/display_scan_4x7seg.sv
// Four-digit multiplexed 7-segment driver for common-anode displays.
// Digit values are double-buffered so each scanned frame shows one consistent value set.
module display_scan_4x7seg #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] digit_4,
  input  logic [3:0] dp_en,
  input  logic       blank_lz,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic          tick;
  logic          frame_boundary;
  logic [19:0]   load_word;
  logic [19:0]   shadow;
  logic [19:0]   active;
  logic [3:0]    slot_val [4];
  logic [3:0]    blank;
  logic [3:0]    cur_val;
  logic [6:0]    seg_next;

  // Packed as {digit_1, digit_2, digit_3, digit_4, dp_en}
  assign load_word      = {digit_1, digit_2, digit_3, digit_4, dp_en};
  assign tick           = (prescaler == PRE_MAX);
  assign frame_boundary = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= 2'd0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // A load landing on the boundary bypasses straight into the active set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load)
        shadow <= load_word;
      if (frame_boundary)
        active <= load ? load_word : shadow;
    end
  end

  assign slot_val[0] = active[7:4];
  assign slot_val[1] = active[11:8];
  assign slot_val[2] = active[15:12];
  assign slot_val[3] = active[19:16];

  // Blanking ripples down from the most significant slot; slot 0 always shows
  assign blank[3] = blank_lz && (slot_val[3] == 4'd0);
  assign blank[2] = blank[3] && (slot_val[2] == 4'd0);
  assign blank[1] = blank[2] && (slot_val[1] == 4'd0);
  assign blank[0] = 1'b0;

  assign cur_val = slot_val[idx];

  always_comb begin
    seg_next = 7'b1111111;
    case (cur_val)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      4'hF: seg_next = 7'b0001110;
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_boundary;
      if (blank[idx]) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= seg_next;
        dp  <= ~active[idx];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_4x7seg.sv
// Directed bench for display_scan_4x7seg: a REFRESH_DIV=4 instance for frame behaviour
// and a REFRESH_DIV=1 instance sharing the same inputs for the every-cycle stepping case.
module tb_display_scan_4x7seg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_1, digit_2, digit_3, digit_4, dp_en;
  logic       blank_lz, load;
  logic [3:0] an, an1;
  logic [6:0] seg, seg1;
  logic       dp, dp1, frame_done, frame_done1;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] an_slot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  display_scan_4x7seg #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3), .digit_4(digit_4),
    .dp_en(dp_en), .blank_lz(blank_lz), .load(load),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  display_scan_4x7seg #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3), .digit_4(digit_4),
    .dp_en(dp_en), .blank_lz(blank_lz), .load(load),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns on the negedge where frame_done is seen high, or gives up after 40 cycles
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0; dp_en = 4'h0;
    digit_1 = 4'h0; digit_2 = 4'h0; digit_3 = 4'h0; digit_4 = 4'h0;
    #3;
    vectors++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_div4: an=%b seg=%b dp=%b fd=%b, expected 1111 1111111 1 0", an, seg, dp, frame_done);
    end
    vectors++;
    if ({an1, seg1, dp1, frame_done1} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_div1: an=%b seg=%b dp=%b fd=%b, expected 1111 1111111 1 0", an1, seg1, dp1, frame_done1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL first_edge: an=%b seg=%b dp=%b, expected 1110 1000000 1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    logic [6:0] s_exp [4];
    bit ok;
    s_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    digit_1 = 4'h1; digit_2 = 4'h2; digit_3 = 4'h3; digit_4 = 4'h4; dp_en = 4'h0;
    pulse_load();
    wait_frame(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL scan_sync: frame_done=0, expected a pulse within 40 cycles");
    end
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {an_slot[k], s_exp[k], 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL scan slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", k, an, seg, dp, an_slot[k], s_exp[k]);
      end
      if (k == 1) begin
        vectors++;
        if (frame_done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL scan frame_done_mid: got %b, expected 0", frame_done);
        end
      end
      repeat (2) @(negedge clk);
    end
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL scan frame_period: frame_done=%b, expected 1 after 16 cycles", frame_done);
    end
  endtask

  task automatic test_mid_frame_load();
    logic [6:0] s_exp [4];
    s_exp = '{7'b0001110, 7'b1111000, 7'b1000000, 7'b1000000};
    blank_lz = 1'b0;
    repeat (6) @(negedge clk);
    digit_1 = 4'h0; digit_2 = 4'h0; digit_3 = 4'h7; digit_4 = 4'hF;
    pulse_load();
    repeat (3) @(negedge clk);
    vectors++;
    if ({an, seg} !== {4'b1011, 7'b0100100}) begin
      miscompares++;
      $display("[TB] FAIL midload old_slot2: an=%b seg=%b, expected an=1011 seg=0100100", an, seg);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({an, seg} !== {4'b0111, 7'b1111001}) begin
      miscompares++;
      $display("[TB] FAIL midload old_slot3: an=%b seg=%b, expected an=0111 seg=1111001", an, seg);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midload boundary: frame_done=%b, expected 1", frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {an_slot[k], s_exp[k], 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL midload new slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", k, an, seg, dp, an_slot[k], s_exp[k]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_blank();
    logic [3:0] a_exp [4];
    logic [6:0] s_exp [4];
    blank_lz = 1'b1;
    digit_1 = 4'h0; digit_2 = 4'h0; digit_3 = 4'h0; digit_4 = 4'h0;
    a_exp = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    s_exp = '{7'b0001110, 7'b1111000, 7'b1111111, 7'b1111111};
    for (int k = 0; k < 4; k++) begin
      if (k == 0) pulse_load(); else @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {a_exp[k], s_exp[k], 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL blank_007F slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", k, an, seg, dp, a_exp[k], s_exp[k]);
      end
      repeat (2) @(negedge clk);
    end
    a_exp = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    s_exp = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {a_exp[k], s_exp[k], 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL blank_zero slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", k, an, seg, dp, a_exp[k], s_exp[k]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_coincident_load();
    blank_lz = 1'b0;
    repeat (15) @(negedge clk);
    digit_1 = 4'h8; digit_2 = 4'h8; digit_3 = 4'h8; digit_4 = 4'h8;
    pulse_load();
    digit_1 = 4'h0; digit_2 = 4'h0; digit_3 = 4'h0; digit_4 = 4'h0;
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL coincident boundary: frame_done=%b, expected 1", frame_done);
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        repeat (2) @(negedge clk);
        vectors++;
        if ({an, seg, dp} !== {an_slot[k], 7'b0000000, 1'b1}) begin
          miscompares++;
          $display("[TB] FAIL coincident frame%0d slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=0000000 dp=1", f, k, an, seg, dp, an_slot[k]);
        end
        repeat (2) @(negedge clk);
      end
    end
  endtask

  task automatic test_dp();
    logic d_exp [4];
    logic [6:0] s_exp [4];
    d_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    s_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    digit_1 = 4'h1; digit_2 = 4'h2; digit_3 = 4'h3; digit_4 = 4'h4; dp_en = 4'b0101;
    pulse_load();
    dp_en = 4'b0000;
    repeat (15) @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dp boundary: frame_done=%b, expected 1", frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {an_slot[k], s_exp[k], d_exp[k]}) begin
        miscompares++;
        $display("[TB] FAIL dp slot%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", k, an, seg, dp, an_slot[k], s_exp[k], d_exp[k]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] a1_exp [5];
    logic       f1_exp [5];
    bit ok;
    a1_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    f1_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    digit_1 = 4'h9; digit_2 = 4'h9; digit_3 = 4'h9; digit_4 = 4'h9;
    pulse_load();
    repeat (9) @(negedge clk);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, 7'b0100100, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rstmid pre_slot2: an=%b seg=%b dp=%b, expected an=1011 seg=0100100 dp=0", an, seg, dp);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rstmid async: an=%b seg=%b dp=%b fd=%b, expected 1111 1111111 1 0", an, seg, dp, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      vectors++;
      if ({an1, seg1, dp1, frame_done1} !== {a1_exp[j], 7'b1000000, 1'b1, f1_exp[j]}) begin
        miscompares++;
        $display("[TB] FAIL rstmid div1 step%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=1000000 dp=1 fd=%b", j, an1, seg1, dp1, frame_done1, a1_exp[j], f1_exp[j]);
      end
      if (j == 0) begin
        vectors++;
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
          miscompares++;
          $display("[TB] FAIL rstmid first_edge: an=%b seg=%b dp=%b, expected 1110 1000000 1", an, seg, dp);
        end
      end
    end
    wait_frame(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL rstmid sync: frame_done=0, expected a pulse within 40 cycles");
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      miscompares++;
      $display("[TB] FAIL rstmid shadow_lost: an=%b seg=%b, expected an=1110 seg=1000000", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_frame_load();
    test_blank();
    test_coincident_load();
    test_dp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_4x7seg.md
Name: display_scan_4x7seg

Overview:
Consumes the four 4-bit digit values from the 16-bit nibble splitter and drives four multiplexed common-anode 7-segment digits on the Nexys 4 DDR.
- Double-buffers the digit values so a display frame never shows a mix of old and new data.
- Scans one digit per refresh tick and hex-decodes it to active-low segment signals.
- Optionally blanks leading zeros.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit step (≥1); 1 kHz digit rate at 100 MHz.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digit_1  in  4  most significant digit value (leftmost, an[3])
digit_2  in  4  second digit (an[2])
digit_3  in  4  third digit (an[1])
digit_4  in  4  least significant digit (rightmost, an[0])
dp_en  in  4  decimal point enable per digit, bit i maps to an[i], active-high
blank_lz  in  1  leading-zero blanking enable, sampled live
load  in  1  single-cycle strobe; captures digit_1..4 and dp_en
an  out  4  anode enables, active-low
seg  out  7  segments, active-low; seg[0]=CA … seg[6]=CG
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
One clock domain. Reset is asynchronous and active-high.

Reset values:
- Prescaler = 0, idx = 0.
- Shadow and active registers = 0.
- an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.

Prescaler:
- Counts 0..REFRESH_DIV-1, then wraps.
- tick = (prescaler == REFRESH_DIV-1).
- With REFRESH_DIV=1, tick is asserted every cycle.

Digit index:
- 2-bit idx increments mod 4 on tick.
- idx i selects an[i]. idx0 = digit_4, idx3 = digit_1.

Frame boundary:
- frame_boundary = tick && idx==3.
- frame_done is registered and equals frame_boundary delayed by one cycle.

Buffering:
- On load, shadow <= {digit_1..digit_4, dp_en}.
- On frame_boundary, active <= shadow.
- If load and frame_boundary occur in the same cycle, active takes the new inputs directly (bypass), and shadow also takes them.
- A load that does not coincide with a boundary becomes visible starting at idx0 of the next frame.
- Multiple loads within one frame: the last one wins.

Output stage:
- an, seg and dp are registered from the current idx and active register.
- They change exactly one cycle after idx changes.
- The first post-reset clock edge drives idx0: an=4'b1110 and the active digit_4 decode.
- Exactly one an bit is low at any time after that first edge.

Hex decode (seg[6:0], active-low):

| Value | seg[6:0] | Value | seg[6:0] |
|---|---|---|---|
| 0 | 1000000 | 8 | 0000000 |
| 1 | 1111001 | 9 | 0010000 |
| 2 | 0100100 | A | 0001000 |
| 3 | 0110000 | b | 0000011 |
| 4 | 0011001 | C | 1000110 |
| 5 | 0010010 | d | 0100001 |
| 6 | 0000010 | E | 0000110 |
| 7 | 1111000 | F | 0001110 |

dp:
- dp = ~active_dp_en[idx].

Leading-zero blanking (blank_lz=1):
- A digit is blank if it and every more significant active digit equal 0.
- digit_4 (an[0]) is never blanked.
- A blank digit drives an=4'b1111, seg=7'b1111111, dp=1 for its slot.
- Scan timing is unchanged by blanking.

Reset mid-operation:
- All state returns to reset values immediately, asynchronously.
- Scan resumes from idx0 after release; pending shadow data is lost.

Test Plan:
1. Reset, then REFRESH_DIV=4, load 16'h1234 values (1,2,3,4) with dp_en=0 → in steady state, an cycles 1110→1101→1011→0111 every 4 cycles. seg shows 4 (0011001), 3, 2, 1 (1111001) respectively; dp=1; frame_done pulses every 16 cycles.
2. Load 0,0,7,F mid-frame with blank_lz=0 → old values persist until the boundary. The next frame shows F(0001110), 7, 0, 0 with no mixed frame.
3. Same 0,0,7,F with blank_lz=1 → slots for an[3] and an[2] are fully off (an=1111, seg=1111111). an[1] shows 7, an[0] shows F. With all digits 0, only an[0] shows 0 (1000000).
4. load coincident with frame_boundary (value 8,8,8,8) → the next frame already shows 8 (0000000) on all digits; shadow=8888.
5. dp_en=4'b0101 → dp=0 during the an[0] and an[2] slots, dp=1 otherwise.
6. Assert reset during the idx2 slot with an asynchronous edge between clocks → outputs go to all-ones immediately. After release, the first edge gives an=1110 with seg=1000000 (active cleared); a REFRESH_DIV=1 run steps idx every cycle.
